// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the register-bank write arbiter and its
// one-hot decoder.
//   DATA_W / ADDR_W / NREG : bank geometry (32 x 32-bit registers)
//   CNT_W                  : width of the saturating dropped-write counter
//   REQ_A / REQ_B          : round-robin pointer encoding
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 1 << ADDR_W;
  localparam int CNT_W  = 8;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/regfile_decoder_onehot.sv
// regfile_decoder_onehot: register index -> one-hot select vector.
//   en_i     : enable; output is all-zero when low
//   addr_i   : register index
//   onehot_o : bit i set iff en_i && addr_i == i && i != 0
// Register 0 is hard-wired, so its select bit is never driven. Also usable
// for the bank's read-side select.
module regfile_decoder_onehot #(
  parameter int ADDR_W = 5,
  parameter int NREG   = 1 << ADDR_W
) (
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NREG-1:0]   onehot_o
);

  assign onehot_o[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_sel
    assign onehot_o[i] = en_i && (addr_i == ADDR_W'(i));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register bank's single write port between
// requester A (ALU) and B (load unit) with round-robin arbitration and a
// one-cycle issue stage.
//   clk, reset            : clock, synchronous active-high reset
//   hold                  : stall; no grants while high
//   a_valid/a_addr/a_data : requester A write, a_ready = A accepted (comb)
//   b_valid/b_addr/b_data : requester B write, b_ready = B accepted (comb)
//   wr_en/wr_addr/wr_data : registered write to the bank
//   wr_onehot             : registered per-register write enables
//   drop_cnt              : saturating count of accepted writes to register 0
// Optional (macro REGFILE_ARB_FWD_EN): rd_addr0/1 in, fwd_hit0/1 and
// fwd_data0/1 out, bypassing the write held in the issue stage.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int CNT_W  = regfile_pkg::CNT_W,
  parameter int NREG   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREG-1:0]   wr_onehot,
  output logic [CNT_W-1:0]  drop_cnt
`ifdef REGFILE_ARB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic              fwd_hit0,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data0,
  output logic [DATA_W-1:0] fwd_data1
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic              ptr_q, ptr_d;
  logic              gnt_a, gnt_b, acc, contend;
  wr_req_t           sel;
  logic [NREG-1:0]   onehot_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [NREG-1:0]   wr_onehot_q;
  logic [CNT_W-1:0]  drop_q, drop_d;

  // Grant depends only on requests, hold and the pointer -- never on the
  // issue stage -- so the write port sustains one write per cycle.
  always_comb begin
    contend = a_valid && b_valid;
    gnt_a   = !hold && a_valid && (!b_valid || ptr_q == REQ_A);
    gnt_b   = !hold && b_valid && (!a_valid || ptr_q == REQ_B);
    acc     = gnt_a || gnt_b;
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  always_comb begin
    sel = gnt_a ? '{addr: a_addr, data: a_data} : '{addr: b_addr, data: b_data};
  end

  regfile_decoder_onehot #(.ADDR_W(ADDR_W), .NREG(NREG)) u_dec (
    .en_i    (acc),
    .addr_i  (sel.addr),
    .onehot_o(onehot_d)
  );

  always_comb begin
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = drop_q;
    // Pointer moves only on a contested grant, and then names the loser.
    if (contend && acc) ptr_d = gnt_a ? REQ_B : REQ_A;
    if (acc) begin
      wr_addr_d = sel.addr;
      wr_data_d = sel.data;
      // Register 0 is read-only zero: swallow the write but count it.
      if (sel.addr == '0 && drop_q != '1) drop_d = drop_q + 1'b1;
    end
    wr_en_d = acc && (sel.addr != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= REQ_A;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_onehot_q <= '0;
      drop_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_onehot_q <= onehot_d;
      drop_q      <= drop_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_onehot = wr_onehot_q;
  assign drop_cnt  = drop_q;

`ifdef REGFILE_ARB_FWD_EN
  // Bypass the write the bank commits at the coming edge.
  assign fwd_hit0  = wr_en_q && (wr_addr_q == rd_addr0) && (rd_addr0 != '0);
  assign fwd_hit1  = wr_en_q && (wr_addr_q == rd_addr1) && (rd_addr1 != '0);
  assign fwd_data0 = fwd_hit0 ? wr_data_q : '0;
  assign fwd_data1 = fwd_hit1 ? wr_data_q : '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_onehot;
  logic [7:0]  drop_cnt;
`ifdef REGFILE_ARB_FWD_EN
  logic [4:0]  rd_addr0 = '0, rd_addr1 = '0;
  logic        fwd_hit0, fwd_hit1;
  logic [31:0] fwd_data0, fwd_data1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .reset(reset), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_onehot(wr_onehot), .drop_cnt(drop_cnt)
`ifdef REGFILE_ARB_FWD_EN
    , .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .fwd_hit0(fwd_hit0), .fwd_hit1(fwd_hit1),
    .fwd_data0(fwd_data0), .fwd_data1(fwd_data1)
`endif
  );

  typedef struct {
    logic        hold;
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        ea;   // expected a_ready
    logic        eb;   // expected b_ready
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] onehot;
    logic [7:0]  drop;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [7:0]  m_drop;

  function automatic vec_t mk(logic h, logic av, logic [4:0] aa, logic [31:0] ad,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic ea, logic eb);
    vec_t v;
    v.hold = h; v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, check readies mid-cycle, push the expected issue-stage
  // contents, then pop and compare them just after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    hold = v.hold; a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    #1;
    chk("a_ready", {31'b0, a_ready}, {31'b0, v.ea});
    chk("b_ready", {31'b0, b_ready}, {31'b0, v.eb});
    e.en = 1'b0; e.onehot = '0;
    if (v.ea || v.eb) begin
      m_addr = v.ea ? v.aa : v.ba;
      m_data = v.ea ? v.ad : v.bd;
      if (m_addr == 0) begin
        if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      end else begin
        e.en = 1'b1;
        e.onehot = 32'd1 << m_addr;
      end
    end
    e.addr = m_addr; e.data = m_data; e.drop = m_drop;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("wr_en", {31'b0, wr_en}, {31'b0, e.en});
    chk("wr_onehot", wr_onehot, e.onehot);
    chk("drop_cnt", {24'b0, drop_cnt}, {24'b0, e.drop});
    if (e.en) begin
      chk("wr_addr", {27'b0, wr_addr}, {27'b0, e.addr});
      chk("wr_data", wr_data, e.data);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; hold = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_addr", {27'b0, wr_addr}, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_onehot", wr_onehot, 32'd0);
    chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
    m_addr = '0; m_data = '0; m_drop = '0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t tbl[15];

  initial begin
    reset = 1'b1; hold = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    m_addr = '0; m_data = '0; m_drop = '0;

    //            hold av aa  ad             bv ba  bd            ea eb
    tbl[0]  = mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        1, 0); // A only
    tbl[1]  = mk(0, 1, 3,  32'h11111111, 1, 4,  32'h22222222, 1, 0); // ptr A
    tbl[2]  = mk(0, 1, 3,  32'h11111111, 1, 4,  32'h22222222, 0, 1);
    tbl[3]  = mk(0, 1, 3,  32'h33333333, 1, 4,  32'h22222222, 1, 0);
    tbl[4]  = mk(0, 1, 3,  32'h33333333, 1, 4,  32'h44444444, 0, 1);
    tbl[5]  = mk(0, 0, 0,  32'h0,        1, 0,  32'hFFFFFFFF, 0, 1); // reg 0
    tbl[6]  = mk(1, 1, 7,  32'h77777777, 1, 9,  32'h99999999, 0, 0); // hold
    tbl[7]  = mk(1, 1, 7,  32'h77777777, 1, 9,  32'h99999999, 0, 0);
    tbl[8]  = mk(1, 1, 7,  32'h77777777, 1, 9,  32'h99999999, 0, 0);
    tbl[9]  = mk(0, 1, 7,  32'h77777777, 1, 9,  32'h99999999, 1, 0); // ptr A
    tbl[10] = mk(0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0); // idle
    tbl[11] = mk(0, 0, 0,  32'h0,        1, 31, 32'hCAFEF00D, 0, 1); // top bit
    tbl[12] = mk(0, 1, 1,  32'h00000101, 0, 0,  32'h0,        1, 0); // ptr B kept
    tbl[13] = mk(0, 1, 6,  32'h0000AAAA, 1, 6,  32'h0000BBBB, 0, 1); // same addr
    tbl[14] = mk(0, 1, 6,  32'h0000AAAA, 0, 0,  32'h0,        1, 0);

    do_reset();
    for (int i = 0; i < 15; i++) step(tbl[i]);
    // Last same-address grant (A) must be what the bank holds.
    chk("same_addr_final", wr_data, 32'h0000AAAA);

    // Drop counter saturation: drop_cnt is 1 here; 254 more reach 255,
    // further writes must not wrap.
    for (int i = 0; i < 260; i++)
      step(mk(0, 0, 0, 32'h0, 1, 0, 32'hFFFFFFFF, 0, 1));
    chk("drop_sat", {24'b0, drop_cnt}, 32'd255);

    // Move pointer to B, accept an A write, then reset mid-stream.
    step(mk(0, 1, 2, 32'h0BADF00D, 1, 8, 32'h88888888, 1, 0)); // ptr -> B
    step(mk(0, 1, 2, 32'h0BADF00D, 0, 0, 32'h0, 1, 0));
    do_reset();
    step(mk(0, 1, 10, 32'hA0A0A0A0, 1, 11, 32'hB0B0B0B0, 1, 0)); // ptr back to A
    // Reset in the very cycle of an acceptance discards that write.
    @(negedge clk);
    reset = 1'b1; a_valid = 1'b1; a_addr = 5'd12; a_data = 32'h12121212; b_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_discard_en", {31'b0, wr_en}, 32'd0);
    chk("rst_discard_onehot", wr_onehot, 32'd0);
    do_reset();

`ifdef REGFILE_ARB_FWD_EN
    step(mk(0, 1, 7, 32'h12345678, 0, 0, 32'h0, 1, 0));
    rd_addr0 = 5'd7; rd_addr1 = 5'd0;
    #1;
    chk("fwd_hit0", {31'b0, fwd_hit0}, 32'd1);
    chk("fwd_data0", fwd_data0, 32'h12345678);
    chk("fwd_hit1", {31'b0, fwd_hit1}, 32'd0);
    chk("fwd_data1", fwd_data1, 32'd0);
    rd_addr1 = 5'd3;
    #1;
    chk("fwd_hit1_miss", {31'b0, fwd_hit1}, 32'd0);
    rd_addr1 = 5'd7;
    #1;
    chk("fwd_hit1_hit", {31'b0, fwd_hit1}, 32'd1);
    chk("fwd_data1_hit", fwd_data1, 32'h12345678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 32x32 register bank (thirty-two 32-bit enable registers) between two writeback requesters: A (ALU) and B (load unit).
- Round-robin arbitration with a valid/ready handshake on each requester.
- Registers the winning write into one issue stage.
- From that stage, drives a one-hot per-register write-enable vector plus data straight into the bank's enable inputs.
- Sits between the pipeline writeback logic and the register bank.

Parameters:
DATA_W, 32, width of write data.
ADDR_W, 5, register index width; NREG = 2**ADDR_W registers.
CNT_W, 8, width of the saturating dropped-write counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
hold  in  1  stall from the control unit; while high, no grant is made.
a_valid  in  1  requester A has a write.
a_addr  in  ADDR_W  requester A destination register.
a_data  in  DATA_W  requester A write data.
a_ready  out  1  A accepted this cycle (combinational).
b_valid  in  1  requester B has a write.
b_addr  in  ADDR_W  requester B destination register.
b_data  in  DATA_W  requester B write data.
b_ready  out  1  B accepted this cycle (combinational).
wr_en  out  1  registered write strobe to the bank.
wr_addr  out  ADDR_W  registered destination index.
wr_data  out  DATA_W  registered data; fans out to every register's d input.
wr_onehot  out  NREG  registered one-hot enable vector; bit i drives register i's wrenable.
drop_cnt  out  CNT_W  saturating count of accepted writes to register 0.

Behaviour:
- Reset (reset=1 at an edge):
  - wr_en=0, wr_addr=0, wr_data=0, wr_onehot=0, drop_cnt=0.
  - Priority pointer := A.
  - Reset overrides any in-flight write; the pending issue-stage write is discarded, not completed.
- Grant (combinational, each cycle, with hold=0):
  - Only A valid -> grant A.
  - Only B valid -> grant B.
  - Both valid -> grant the requester named by the pointer.
  - hold=1 or neither valid -> no grant.
  - a_ready = grant A; b_ready = grant B.
  - At most one ready is high per cycle; ready never depends on the issue-stage contents.
- Pointer: updates only on a cycle where both requesters were valid and one was granted; it then points to the loser. Single-requester grants leave it unchanged.
- Handshake: a write transfers when valid && ready. A requester must hold valid/addr/data stable until it sees ready; the block never drops an unaccepted request.
- Issue stage, 1-cycle latency: the accepted write appears on wr_* in the cycle after acceptance and is committed by the bank at the following edge.
  - Accepted, addr != 0: wr_en=1, wr_addr/wr_data = granted values, wr_onehot = 1 << addr.
  - Accepted, addr == 0: wr_en=0, wr_onehot=0 (register 0 is never written); drop_cnt increments, saturating at 2**CNT_W-1.
  - No acceptance: wr_en=0, wr_onehot=0. wr_addr/wr_data hold their last values.
- Invariants:
  - wr_onehot has at most one bit set.
  - wr_onehot != 0 iff wr_en.
  - Back-to-back acceptances give back-to-back writes; throughput is 1 write/cycle.
- Same-address writes from A and B arriving together: serialised by grant order; the later grant's data is what the bank finally holds.
- hold asserted mid-stream: the already-accepted write still issues the next cycle; no new grants while hold=1.

Optional Feature:
Macro REGFILE_ARB_FWD_EN.
- Defined:
  - Adds inputs rd_addr0, rd_addr1 [ADDR_W] and outputs fwd_hit0, fwd_hit1 [1], fwd_data0, fwd_data1 [DATA_W].
  - fwd_hitN = wr_en && wr_addr == rd_addrN && rd_addrN != 0, combinational from the issue stage.
  - fwd_dataN = wr_data when hit, else 0.
  - Lets read ports bypass the write the bank has not yet committed.
- Undefined: those ports and the logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package regfile_pkg:
  - Constants DATA_W=32, ADDR_W=5, NREG=32.
  - Requester-id constants REQ_A=0, REQ_B=1 (pointer encoding).
- One natural sub-module: regfile_decoder_onehot (ADDR_W -> NREG one-hot with enable input, zero output when disabled or addr==0). It is also reusable for the bank's read-side select.

Test Plan:
- Reset then A-only: a_valid=1, a_addr=5, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_onehot=0x00000020, wr_data=0xDEADBEEF.
- Contention over 4 cycles: A(addr 3) and B(addr 4) both valid continuously -> grants A,B,A,B; wr_onehot sequence 0x08,0x10,0x08,0x10.
- Register 0: B writes addr 0, data 0xFFFFFFFF -> b_ready=1; next cycle wr_en=0, wr_onehot=0, drop_cnt=1; saturation is reached after 255 such writes with CNT_W=8, and drop_cnt then stays at 255.
- hold: both valid, hold=1 for 3 cycles -> a_ready=b_ready=0 and wr_en=0 throughout; on hold release A is granted (pointer still A).
- Reset mid-operation: A accepted at cycle n, reset=1 at cycle n+1 -> wr_en=0 and wr_onehot=0 after that edge, drop_cnt=0, pointer=A.
- With REGFILE_ARB_FWD_EN: issue stage holds addr 7 / 0x12345678, rd_addr0=7, rd_addr1=0 -> fwd_hit0=1, fwd_data0=0x12345678, fwd_hit1=0.
